// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: frame sequencer states, default pixel width and
// the ns-to-cycles helper also used by the bit controller.
package ws2812_pkg;

   localparam int BITWIDTH_DEF = 24;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_LATCH  = 2'd2
   } state_e;

   function automatic int cycles_from_ns(input longint f_clk_hz, input longint t_ns);
      return int'((t_ns * f_clk_hz) / longint'(1_000_000_000));
   endfunction

   function automatic int addr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ws2812_pixel_ram.sv
// Pixel frame store: one write port and a registered, clearable read port.
// WS2812_DOUBLE_BUFFER_EN adds a second bank selected independently for write and read.
module ws2812_pixel_ram #(
   parameter int BITWIDTH = 24,
   parameter int NUM_LEDS = 8,
   parameter int AW       = 3
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [BITWIDTH-1:0] wr_data,
`ifdef WS2812_DOUBLE_BUFFER_EN
   input  logic                wr_bank,
   input  logic                rd_bank,
`endif
   input  logic                rd_en,
   input  logic                rd_clr,
   input  logic [AW-1:0]       rd_addr,
   output logic [BITWIDTH-1:0] rd_data
);

   localparam logic [AW:0] DEPTH = (AW+1)'(NUM_LEDS);

   logic [BITWIDTH-1:0] data_q, data_d;
   logic                wr_ok;

`ifdef WS2812_DOUBLE_BUFFER_EN
   logic [BITWIDTH-1:0] mem [2][NUM_LEDS];
`else
   logic [BITWIDTH-1:0] mem [NUM_LEDS];
`endif

   assign wr_ok   = wr_en && ({1'b0, wr_addr} < DEPTH);
   assign rd_data = data_q;

   // Storage is intentionally left unreset; only the output word is.
   always_ff @(posedge Clk) begin
`ifdef WS2812_DOUBLE_BUFFER_EN
      if (wr_ok) mem[wr_bank][wr_addr] <= wr_data;
`else
      if (wr_ok) mem[wr_addr] <= wr_data;
`endif
   end

   always_comb begin
      data_d = data_q;
      if (rd_clr) begin
         data_d = '0;
      end else if (rd_en) begin
`ifdef WS2812_DOUBLE_BUFFER_EN
         data_d = mem[rd_bank][rd_addr];
`else
         data_d = mem[rd_addr];
`endif
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) data_q <= '0;
      else       data_q <= data_d;
   end

endmodule

// File: rtl/ws2812_strip_feeder.sv
// Frame sequencer feeding pixel words to the WS2812 bit controller, then holding
// the latch interval. WS2812_DOUBLE_BUFFER_EN selects a front/back banked frame store.
module ws2812_strip_feeder
   import ws2812_pkg::*;
#(
   parameter int F_CLK      = 12_000_000,
   parameter int BITWIDTH   = BITWIDTH_DEF,
   parameter int NUM_LEDS   = 8,
   parameter int T_RESET_NS = 60_000
) (
   input  logic                            Clk,
   input  logic                            Reset,
   input  logic                            WrEn,
   input  logic [addr_width(NUM_LEDS)-1:0] WrAddr,
   input  logic [BITWIDTH-1:0]             WrData,
   input  logic                            Start,
   output logic                            Busy,
   output logic [BITWIDTH-1:0]             PixelData,
   output logic                            PixelValid,
   input  logic                            PixelReq,
   output logic                            FrameDone
);

   localparam int RESET_CYCLES = cycles_from_ns(F_CLK, T_RESET_NS);
   localparam int CW = $clog2(RESET_CYCLES + 1);
   localparam int AW = addr_width(NUM_LEDS);
   localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_LEDS - 1);
   localparam logic [CW-1:0] CNT_START = CW'(RESET_CYCLES - 1);

   state_e        state_q, state_d;
   logic [AW-1:0] index_q, index_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          valid_q, valid_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          rd_en, rd_clr;
   logic [AW-1:0] rd_addr;

`ifdef WS2812_DOUBLE_BUFFER_EN
   logic bank_q, bank_d;
`endif

   ws2812_pixel_ram #(
      .BITWIDTH (BITWIDTH),
      .NUM_LEDS (NUM_LEDS),
      .AW       (AW)
   ) u_ram (
      .Clk     (Clk),
      .Reset   (Reset),
      .wr_en   (WrEn),
      .wr_addr (WrAddr),
      .wr_data (WrData),
`ifdef WS2812_DOUBLE_BUFFER_EN
      .wr_bank (~bank_q),
      .rd_bank (bank_d),
`endif
      .rd_en   (rd_en),
      .rd_clr  (rd_clr),
      .rd_addr (rd_addr),
      .rd_data (PixelData)
   );

   always_comb begin
      state_d = state_q;
      index_d = index_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      rd_en   = 1'b0;
      rd_clr  = 1'b0;
      rd_addr = index_q;
`ifdef WS2812_DOUBLE_BUFFER_EN
      bank_d  = bank_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (Start) begin
               index_d = '0;
               rd_en   = 1'b1;
               rd_addr = '0;
               valid_d = 1'b1;
               busy_d  = 1'b1;
               state_d = ST_STREAM;
`ifdef WS2812_DOUBLE_BUFFER_EN
               // Swap in the same edge so the first fetch reads the freshly written bank.
               bank_d  = ~bank_q;
`endif
            end
         end
         ST_STREAM: begin
            if (PixelReq) begin
               if (index_q < LAST_IDX) begin
                  index_d = index_q + 1'b1;
                  rd_en   = 1'b1;
                  rd_addr = index_d;
               end else begin
                  valid_d = 1'b0;
                  rd_clr  = 1'b1;
                  cnt_d   = CNT_START;
                  state_d = ST_LATCH;
               end
            end
         end
         ST_LATCH: begin
            if (cnt_q == '0) begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Registered so FrameDone is high exactly while the counter sits at zero.
      done_d = (state_d == ST_LATCH) && (cnt_d == '0);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         index_q <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef WS2812_DOUBLE_BUFFER_EN
         bank_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef WS2812_DOUBLE_BUFFER_EN
         bank_q  <= bank_d;
`endif
      end
   end

   assign Busy       = busy_q;
   assign PixelValid = valid_q;
   assign FrameDone  = done_q;

endmodule

// File: tb/tb_ws2812_strip_feeder.sv
// Scoreboard bench for ws2812_strip_feeder with NUM_LEDS=3 and a 720-cycle latch.
module tb_ws2812_strip_feeder;

   localparam int NL = 3;
   localparam int RC = 720;
`ifdef WS2812_DOUBLE_BUFFER_EN
   localparam bit DB = 1'b1;
`else
   localparam bit DB = 1'b0;
`endif

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        WrEn = 1'b0;
   logic [1:0]  WrAddr = 2'd0;
   logic [23:0] WrData = 24'd0;
   logic        Start = 1'b0;
   logic        PixelReq = 1'b0;
   logic        Busy, PixelValid, FrameDone;
   logic [23:0] PixelData;

   int checks = 0;
   int failures = 0;

   logic [23:0] mdl [2][NL];
   logic        mfront = 1'b0;
   logic [23:0] exp_q [$];

   ws2812_strip_feeder #(
      .F_CLK      (12_000_000),
      .BITWIDTH   (24),
      .NUM_LEDS   (NL),
      .T_RESET_NS (60_000)
   ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .WrEn       (WrEn),
      .WrAddr     (WrAddr),
      .WrData     (WrData),
      .Start      (Start),
      .Busy       (Busy),
      .PixelData  (PixelData),
      .PixelValid (PixelValid),
      .PixelReq   (PixelReq),
      .FrameDone  (FrameDone)
   );

   always #5 Clk = ~Clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   // Advance one edge; the model applies any write driven into that edge.
   task automatic tick();
      logic wb;
      wb = DB ? ~mfront : 1'b0;
      if (WrEn && int'(WrAddr) < NL) mdl[wb][WrAddr] = WrData;
      @(posedge Clk);
      #1;
   endtask

   task automatic set_wr(input int a, input logic [23:0] d);
      WrEn = 1'b1;
      WrAddr = 2'(a);
      WrData = d;
   endtask

   task automatic wr(input int a, input logic [23:0] d);
      set_wr(a, d);
      tick();
      WrEn = 1'b0;
   endtask

   task automatic do_start();
      logic nf;
      nf = DB ? ~mfront : mfront;
      exp_q.push_back(mdl[nf][0]);
      Start = 1'b1;
      tick();
      Start = 1'b0;
      mfront = nf;
   endtask

   task automatic pop_exp(output logic [23:0] e);
      if (exp_q.size() == 0) e = 'x;
      else e = exp_q.pop_front();
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (3) @(posedge Clk);
      #1;
      checks++;
      if (Busy !== 1'b0 || PixelValid !== 1'b0 || FrameDone !== 1'b0 || PixelData !== 24'd0) begin
         failures++;
         $display("FAIL reset_hold busy=%b valid=%b done=%b data=%h required 0/0/0/000000",
                  Busy, PixelValid, FrameDone, PixelData);
      end
      Reset = 1'b0;
      tick();
      checks++;
      if (Busy !== 1'b0 || PixelValid !== 1'b0 || FrameDone !== 1'b0 || PixelData !== 24'd0) begin
         failures++;
         $display("FAIL reset_release busy=%b valid=%b done=%b data=%h required 0/0/0/000000",
                  Busy, PixelValid, FrameDone, PixelData);
      end
   endtask

   task automatic test_frame(input string tag, input bit init, input bit poke, input bit mid);
      logic [23:0] e;
      int n;
      if (init) begin
         wr(0, 24'hFF0000);
         wr(1, 24'h00FF00);
         wr(2, 24'h0000FF);
      end
      do_start();
      pop_exp(e);
      checks++;
      if (PixelValid !== 1'b1 || Busy !== 1'b1 || PixelData !== e) begin
         failures++;
         $display("FAIL %s_start valid=%b busy=%b data=%h required 1/1/%h", tag, PixelValid, Busy, PixelData, e);
      end
      for (int k = 0; k < NL; k++) begin
         for (int c = 0; c < 23; c++) begin
            Start = poke && k == 1 && c == 5;
            if (mid && k == 1 && c == 10) set_wr(2, 24'h123456);
            else if (mid && k == 1 && c == 12) set_wr(0, 24'hAAAAAA);
            tick();
            Start = 1'b0;
            WrEn = 1'b0;
         end
         checks++;
         if (PixelData !== e || PixelValid !== 1'b1) begin
            failures++;
            $display("FAIL %s_hold%0d data=%h valid=%b required %h/1", tag, k, PixelData, PixelValid, e);
         end
         if (mid && k == 0) set_wr(1, 24'hABCDEF);
         if (k < NL - 1) exp_q.push_back(mdl[mfront][k+1]);
         PixelReq = 1'b1;
         tick();
         PixelReq = 1'b0;
         WrEn = 1'b0;
         if (k < NL - 1) begin
            pop_exp(e);
            checks++;
            if (PixelData !== e || PixelValid !== 1'b1) begin
               failures++;
               $display("FAIL %s_word%0d data=%h valid=%b required %h/1", tag, k + 1, PixelData, PixelValid, e);
            end
         end else begin
            checks++;
            if (PixelValid !== 1'b0 || PixelData !== 24'd0 || Busy !== 1'b1) begin
               failures++;
               $display("FAIL %s_last valid=%b data=%h busy=%b required 0/000000/1", tag, PixelValid, PixelData, Busy);
            end
         end
      end
      n = 0;
      while (FrameDone !== 1'b1 && n < RC + 50) begin
         if (poke && n == 100) begin
            PixelReq = 1'b1;
            set_wr(3, 24'h55AA55);
         end
         tick();
         PixelReq = 1'b0;
         WrEn = 1'b0;
         n++;
      end
      checks++;
      if (n !== RC - 1 || Busy !== 1'b1) begin
         failures++;
         $display("FAIL %s_done_time edges=%0d busy=%b required %0d/1", tag, n, Busy, RC - 1);
      end
      Start = poke;
      tick();
      Start = 1'b0;
      checks++;
      if (FrameDone !== 1'b0 || Busy !== 1'b0 || PixelValid !== 1'b0) begin
         failures++;
         $display("FAIL %s_end done=%b busy=%b valid=%b required 0/0/0", tag, FrameDone, Busy, PixelValid);
      end
      repeat (3) tick();
      checks++;
      if (Busy !== 1'b0 || PixelValid !== 1'b0) begin
         failures++;
         $display("FAIL %s_idle busy=%b valid=%b required 0/0", tag, Busy, PixelValid);
      end
   endtask

   task automatic test_reset_midframe();
      logic [23:0] e;
      int seen;
      wr(0, 24'h111111);
      wr(1, 24'h222222);
      wr(2, 24'h333333);
      do_start();
      pop_exp(e);
      checks++;
      if (PixelData !== e) begin
         failures++;
         $display("FAIL midrst_word0 data=%h required %h", PixelData, e);
      end
      repeat (23) tick();
      exp_q.push_back(mdl[mfront][1]);
      PixelReq = 1'b1;
      tick();
      PixelReq = 1'b0;
      pop_exp(e);
      checks++;
      if (PixelData !== e) begin
         failures++;
         $display("FAIL midrst_word1 data=%h required %h", PixelData, e);
      end
      #3 Reset = 1'b1;
      #1;
      checks++;
      if (Busy !== 1'b0 || PixelValid !== 1'b0 || FrameDone !== 1'b0 || PixelData !== 24'd0) begin
         failures++;
         $display("FAIL midrst_async busy=%b valid=%b done=%b data=%h required 0/0/0/000000",
                  Busy, PixelValid, FrameDone, PixelData);
      end
      repeat (2) @(posedge Clk);
      #1 Reset = 1'b0;
      mfront = 1'b0;
      exp_q.delete();
      seen = 0;
      repeat (RC + 20) begin
         tick();
         if (FrameDone !== 1'b0 || Busy !== 1'b0) seen++;
      end
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("FAIL midrst_no_done active_cycles=%0d required 0", seen);
      end
   endtask

   task automatic test_oob_idle();
      set_wr(3, 24'h55AA55);
      PixelReq = 1'b1;
      tick();
      PixelReq = 1'b0;
      WrEn = 1'b0;
      repeat (2) tick();
      checks++;
      if (Busy !== 1'b0 || PixelValid !== 1'b0 || PixelData !== 24'd0 || FrameDone !== 1'b0) begin
         failures++;
         $display("FAIL oob_idle busy=%b valid=%b data=%h done=%b required 0/0/000000/0",
                  Busy, PixelValid, PixelData, FrameDone);
      end
   endtask

   initial begin
      test_reset();
      test_frame("basic", 1'b1, 1'b0, 1'b0);
      test_frame("start_ignored", 1'b1, 1'b1, 1'b0);
      test_reset_midframe();
      test_frame("after_reset", 1'b0, 1'b0, 1'b0);
      test_frame("live_update", 1'b1, 1'b0, 1'b1);
      test_frame("next_frame", 1'b0, 1'b0, 1'b0);
      test_oob_idle();
      test_frame("oob_frame", 1'b0, 1'b0, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ws2812_strip_feeder.md
# ws2812_strip_feeder

Frame-level sequencer directly upstream of the WS2812 bit controller. Holds one frame of NUM_LEDS GRB pixel words written by the host, streams them one word per request into the bit controller's data input, then holds the line idle for the WS2812 latch/reset interval before reporting frame completion. Sits between the host/pattern logic and the bit controller.

## Interface
- F_CLK, 12_000_000: clock frequency in Hz.
- BITWIDTH, 24: pixel word width (GRB, MSB sent first by the downstream stage).
- NUM_LEDS, 8: pixels per frame, ≥1.
- T_RESET_NS, 60_000: latch low time in ns (must exceed 50 us); RESET_CYCLES = T_RESET_NS*F_CLK/10**9 (720 at defaults).

- Clk  in  1  system clock, all logic on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- WrEn  in  1  pixel write strobe.
- WrAddr  in  $clog2(NUM_LEDS) (min 1)  pixel index; addresses ≥ NUM_LEDS ignored.
- WrData  in  BITWIDTH  pixel value.
- Start  in  1  one-cycle frame start request.
- Busy  out  1  high from Start acceptance through end of latch interval.
- PixelData  out  BITWIDTH  word presented to the bit controller's Indata.
- PixelValid  out  1  high while PixelData holds a word the bit controller must send.
- PixelReq  in  1  one-cycle pulse (bit controller Done) meaning the current word is consumed and the next is needed.
- FrameDone  out  1  one-cycle pulse at end of latch interval.

## Operation
- States: IDLE, STREAM, LATCH.
- IDLE: Start=1 → index←0, PixelData←mem[0], PixelValid←1, Busy←1, go STREAM. PixelReq ignored.
- STREAM: on PixelReq, if index < NUM_LEDS-1 → index←index+1, PixelData←mem[index+1]; else PixelValid←0, PixelData←0, counter←RESET_CYCLES-1, go LATCH. No PixelReq → outputs hold.
- LATCH: counter decrements each cycle; at 0 → FrameDone pulses for that one cycle, Busy←0, go IDLE next cycle. PixelReq ignored.
- Start outside IDLE ignored (not queued), including the FrameDone cycle.
- Writes accepted in every state. Simultaneous write and fetch of the same address: fetch returns the old value.
- Memory contents are not reset; all control registers are.
- Reset values: state IDLE, PixelData 0, PixelValid 0, Busy 0, FrameDone 0, index 0, counter 0. Reset mid-frame aborts immediately; no FrameDone.
- Counter width $clog2(RESET_CYCLES+1); index width as WrAddr; no wrap beyond NUM_LEDS-1.

## Timing
- Start at edge n → PixelValid, Busy, PixelData=mem[0] visible after edge n.
- PixelReq at edge m → next word visible after edge m (1-cycle latency), in time for the bit controller's next bit-0 high phase.
- Last PixelReq at edge m → PixelValid low after m; FrameDone high in the cycle after edge m+RESET_CYCLES-1; Busy low one edge later.
- Min Start-to-Start frame period: NUM_LEDS word times + RESET_CYCLES + 1.

## Configuration
- WS2812_DOUBLE_BUFFER_EN defined: two banks. Writes always go to the back bank; Start acceptance swaps banks in the same edge, so the frame streams the bank just written and subsequent writes never tear the displayed frame.
- Undefined: single bank; a write to an address not yet fetched in the current frame is visible in that frame.

## Structure
- Package ws2812_pkg: state enum, cycles-from-ns constant function, shared BITWIDTH default; the bit controller reuses the timing function.
- One sub-module: ws2812_pixel_ram (write port, registered read port, bank select present only under WS2812_DOUBLE_BUFFER_EN).

## Test plan
- NUM_LEDS=3, write 0xFF0000/0x00FF00/0x0000FF, Start, PixelReq every 24 cycles → PixelData sequence matches, PixelValid falls after 3rd req, FrameDone exactly 720 cycles later, Busy falls next edge.
- Start pulsed during STREAM and on FrameDone cycle → ignored; no second frame; Busy timing unchanged.
- Reset asserted mid-STREAM (after 1st req) → all outputs 0 asynchronously, no FrameDone; new Start after release streams from mem[0].
- Single-bank build: write addr 2 = 0x123456 before 2nd PixelReq → 3rd word 0x123456; write to addr 0 same frame → appears only next frame.
- Double-buffer build: write addr 1 = 0xABCDEF during STREAM → current frame unchanged; next Start streams 0xABCDEF at index 1.
- WrAddr=3 with NUM_LEDS=3, PixelReq while IDLE/LATCH → no memory change, no state change.
